fetch_sequencer: RTL

Multi-cycle control FSM for the d16 core. It owns the program counter and sequences each instruction through fetch, decode and execution, optionally followed by a memory access and register writeback. It drives the decoder's `en`, latches the instruction word and the optional immediate word, and arbitrates the single memory port between instruction fetch and data access. It sits between the memory interface, the decoder and the ALU/register-file datapath.

---
 rtl/fetch_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle control FSM for the d16 core.
// Owns the PC, latches instruction words and arbitrates the memory port.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PC_STEP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic [15:0] pc,
    output logic [15:0] instr,
    output logic [15:0] imm_word,
    output logic        dec_en,
    input  logic        next_word,
    input  logic        en_mem,
    input  logic        mem_store,
    output logic        alu_en,
    output logic        reg_we,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        halt_req,
    output logic        halted
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EVAL,
        IMM,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [15:0] STEP     = 16'(PC_STEP);
    localparam logic [15:0] PC_RESET = RESET_PC & 16'hFFFE;

    state_t state;
    logic   store_q;
    logic   hs;

    assign hs = mem_req && mem_ready;

    // Strobes are set on the edge that enters the state they belong to,
    // so every output is a registered function of the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= PC_RESET;
            instr        <= 16'h0000;
            imm_word     <= 16'h0000;
            store_q      <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            dec_en       <= 1'b0;
            alu_en       <= 1'b0;
            reg_we       <= 1'b0;
            halted       <= 1'b0;
        end else begin
            dec_en <= 1'b0;
            alu_en <= 1'b0;
            reg_we <= 1'b0;
            case (state)
                FETCH: begin
                    if (hs) begin
                        instr   <= mem_rdata;
                        pc      <= pc + STEP;
                        mem_req <= 1'b0;
                        dec_en  <= 1'b1;
                        state   <= DECODE;
                    end else begin
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr_sel <= 1'b0;
                    end
                end
                DECODE: begin
                    state <= EVAL;
                end
                EVAL: begin
                    if (next_word) begin
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr_sel <= 1'b0;
                        state        <= IMM;
                    end else begin
                        alu_en <= 1'b1;
                        state  <= EXEC;
                    end
                end
                IMM: begin
                    if (hs) begin
                        imm_word <= mem_rdata;
                        pc       <= pc + STEP;
                        mem_req  <= 1'b0;
                        alu_en   <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (en_mem) begin
                        store_q      <= mem_store;
                        mem_req      <= 1'b1;
                        mem_we       <= mem_store;
                        mem_addr_sel <= 1'b1;
                        state        <= MEM;
                    end else begin
                        store_q <= 1'b0;
                        reg_we  <= 1'b1;
                        state   <= WB;
                    end
                end
                MEM: begin
                    if (hs) begin
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        mem_addr_sel <= 1'b0;
                        reg_we       <= !store_q;
                        state        <= WB;
                    end
                end
                WB: begin
                    if (branch_taken) begin
                        pc <= branch_target & 16'hFFFE;
                    end
                    if (halt_req) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr_sel <= 1'b0;
                        state        <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    mem_req      <= 1'b0;
                    mem_we       <= 1'b0;
                    mem_addr_sel <= 1'b0;
                    halted       <= 1'b0;
                    state        <= FETCH;
                end
            endcase
        end
    end

endmodule
